// File: rtl/matrix_mult_3x3_seq.sv
// Sequential 3x3 unsigned matrix multiplier C = A x B, one element per cycle.
// Define MATRIX_MULT_SAT_EN to saturate oversized elements instead of wrapping them.
module matrix_mult_3x3_seq #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2*DATA_W+2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [9*DATA_W-1:0] a_flat,
   input  logic [9*DATA_W-1:0] b_flat,
   output logic                busy,
   output logic                done,
   output logic                result_valid,
   output logic                overflow,
   output logic [9*DATA_W-1:0] matrix_result
);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t              state_q, state_d;
   logic [3:0]          idx_q, idx_d;
   logic [9*DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;

   logic [DATA_W-1:0]   aM [9];
   logic [DATA_W-1:0]   bM [9];
   logic [1:0]          rowSel;
   logic [3:0]          rowBase, colSel;
   logic [2*DATA_W-1:0] p0, p1, p2;
   logic [ACC_W-1:0]    sum;
   logic                sumOvf;
   logic [DATA_W-1:0]   elemVal;

   for (genvar g = 0; g < 9; g++) begin : g_unpack
      assign aM[g] = a_q[DATA_W*g +: DATA_W];
      assign bM[g] = b_q[DATA_W*g +: DATA_W];
   end

   // Dot product of row idx/3 of A with column idx%3 of B.
   always_comb begin
      rowSel  = (idx_q >= 4'd6) ? 2'd2 : ((idx_q >= 4'd3) ? 2'd1 : 2'd0);
      rowBase = {1'b0, rowSel, 1'b0} + {2'b00, rowSel};
      colSel  = idx_q - rowBase;
      p0 = {{DATA_W{1'b0}}, aM[rowBase]}        * {{DATA_W{1'b0}}, bM[colSel]};
      p1 = {{DATA_W{1'b0}}, aM[rowBase + 4'd1]} * {{DATA_W{1'b0}}, bM[colSel + 4'd3]};
      p2 = {{DATA_W{1'b0}}, aM[rowBase + 4'd2]} * {{DATA_W{1'b0}}, bM[colSel + 4'd6]};
      sum    = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2);
      sumOvf = (sum > ACC_W'({DATA_W{1'b1}}));
`ifdef MATRIX_MULT_SAT_EN
      elemVal = sumOvf ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
      elemVal = sum[DATA_W-1:0];
`endif
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COMPUTE;
               a_d     = a_flat;
               b_d     = b_flat;
               idx_d   = 4'd0;
               valid_d = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         COMPUTE: begin
            c_d[DATA_W*idx_q +: DATA_W] = elemVal;
            ovf_d = ovf_q | sumOvf;
            if (idx_q == 4'd8) begin
               state_d = DONE;
               idx_d   = 4'd0;
               valid_d = 1'b1;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy          = (state_q == COMPUTE);
   assign done          = (state_q == DONE);
   assign result_valid  = valid_q;
   assign overflow      = ovf_q;
   assign matrix_result = c_q;

endmodule

// File: tb/tb_matrix_mult_3x3_seq.sv
// Testbench for matrix_mult_3x3_seq: directed runs with a scoreboard of expected matrices.
module tb_matrix_mult_3x3_seq;

   localparam int DW = 8;

   typedef struct {
      logic [9*DW-1:0] c;
      logic            ovf;
   } sbEntry;

   logic            clk;
   logic            rst;
   logic            start;
   logic [9*DW-1:0] a_flat, b_flat;
   logic            busy, done, result_valid, overflow;
   logic [9*DW-1:0] matrix_result;

   sbEntry sbQ[$];
   int     assertCount = 0;
   int     failCount   = 0;

   matrix_mult_3x3_seq #(.DATA_W(DW)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .a_flat(a_flat),
      .b_flat(b_flat),
      .busy(busy),
      .done(done),
      .result_valid(result_valid),
      .overflow(overflow),
      .matrix_result(matrix_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9*DW-1:0] mk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
      int v[9];
      logic [9*DW-1:0] r;
      v = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
      r = '0;
      for (int i = 0; i < 9; i++) r[DW*i +: DW] = v[i][DW-1:0];
      return r;
   endfunction

   // Reference product computed with plain integer arithmetic.
   function automatic sbEntry model(input logic [9*DW-1:0] aIn, input logic [9*DW-1:0] bIn);
      sbEntry r;
      int s;
      r.c   = '0;
      r.ovf = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            s = 0;
            for (int k = 0; k < 3; k++)
               s += int'(aIn[DW*(3*i+k) +: DW]) * int'(bIn[DW*(3*k+j) +: DW]);
            if (s > 255) begin
               r.ovf = 1'b1;
`ifdef MATRIX_MULT_SAT_EN
               r.c[DW*(3*i+j) +: DW] = 8'hFF;
`else
               r.c[DW*(3*i+j) +: DW] = s[DW-1:0];
`endif
            end else begin
               r.c[DW*(3*i+j) +: DW] = s[DW-1:0];
            end
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [9*DW-1:0] observed,
                              input logic [9*DW-1:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One run: start at the current negedge, then follow it cycle by cycle (k = cycle N+k).
   task automatic applyStimulus(input logic [9*DW-1:0] aIn, input logic [9*DW-1:0] bIn,
                                input int restartAt, input int changeAt, input int resetAt);
      sbEntry e;
      sbQ.push_back(model(aIn, bIn));
      a_flat = aIn;
      b_flat = bIn;
      start  = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         start = (k == restartAt);
         if (k == changeAt) begin
            a_flat = ~aIn;
            b_flat = ~bIn;
         end
         if (resetAt != 0 && k == resetAt + 1) begin
            rst = 1'b0;
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_done", done, 1'b0);
            checkOutput("rst_valid", result_valid, 1'b0);
            checkOutput("rst_ovf", overflow, 1'b0);
            checkOutput("rst_result", matrix_result, '0);
            e = sbQ.pop_front();
            return;
         end
         if (k <= 9) begin
            checkOutput("busy_high", busy, 1'b1);
            checkOutput("done_low", done, 1'b0);
            checkOutput("valid_low", result_valid, 1'b0);
         end else if (k == 10) begin
            checkOutput("done_pulse", done, 1'b1);
            checkOutput("busy_low_done", busy, 1'b0);
            checkOutput("valid_done", result_valid, 1'b1);
            e = sbQ.pop_front();
            checkOutput("result", matrix_result, e.c);
            checkOutput("overflow", overflow, e.ovf);
         end else begin
            checkOutput("done_once", done, 1'b0);
            checkOutput("busy_idle", busy, 1'b0);
            checkOutput("valid_hold", result_valid, 1'b1);
            checkOutput("result_hold", matrix_result, e.c);
         end
         if (k == resetAt) rst = 1'b1;
      end
   endtask

   initial begin
      logic [9*DW-1:0] seq, ident, all200;
      seq    = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);
      ident  = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
      all200 = mk(200, 200, 200, 200, 200, 200, 200, 200, 200);

      rst    = 1'b1;
      start  = 1'b0;
      a_flat = '0;
      b_flat = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_done", done, 1'b0);
      checkOutput("reset_valid", result_valid, 1'b0);
      checkOutput("reset_ovf", overflow, 1'b0);
      checkOutput("reset_result", matrix_result, '0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(seq, ident, 0, 0, 0);
      checkOutput("identity_const", matrix_result, seq);
      applyStimulus(seq, seq, 0, 0, 0);
      checkOutput("AxA_const", matrix_result, mk(30, 36, 42, 66, 81, 96, 102, 126, 150));
      applyStimulus(all200, all200, 0, 0, 0);
`ifdef MATRIX_MULT_SAT_EN
      checkOutput("all200_const", matrix_result, mk(255, 255, 255, 255, 255, 255, 255, 255, 255));
`else
      checkOutput("all200_const", matrix_result, mk(192, 192, 192, 192, 192, 192, 192, 192, 192));
`endif
      checkOutput("all200_ovf", overflow, 1'b1);
      applyStimulus(seq, ident, 3, 4, 0);
      applyStimulus(all200, ident, 10, 0, 0);
      applyStimulus(seq, seq, 0, 0, 5);
      applyStimulus(seq, seq, 0, 0, 0);
      applyStimulus(all200, seq, 0, 0, 0);
      applyStimulus(mk(17, 3, 250, 0, 9, 128, 64, 1, 33), mk(5, 7, 1, 2, 0, 3, 1, 1, 1), 0, 0, 0);

      repeat (3) @(negedge clk);
      checkOutput("idle_valid_hold", result_valid, 1'b1);
      checkOutput("idle_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
